panda_risc_v_commit_pro: RTL

Second-generation commit unit for the Panda RISC-V execute stage. It confirms branches and commits or cancels each retiring instruction. It arbitrates the three standard machine interrupts plus a parametrised bank of platform-local interrupts and a buffered LSU bus-error exception. It sequences pipeline flushes with a held request/acknowledge handshake. Unlike the first generation, it never lets an interrupt or LSU exception overwrite a synchronous exception or ECALL, and it latches a double-fault halt when a synchronous exception occurs inside a trap handler.

---
 rtl/panda_risc_v_pkg.sv | 36 +++
 rtl/panda_risc_v_itr_arbiter.sv | 14 +
 rtl/panda_risc_v_commit_pro.sv | 128 ++++++++++++
 3 files changed

// File: rtl/panda_risc_v_pkg.sv
// panda_risc_v_pkg: shared encodings for the commit unit (error codes, trap causes, FSM states)
package panda_risc_v_pkg;
  localparam logic [2:0] ERR_NONE        = 3'b000;
  localparam logic [2:0] ERR_ILLEGAL     = 3'b001;
  localparam logic [2:0] ERR_PC_MISALIGN = 3'b010;
  localparam logic [2:0] ERR_IMEM_FAULT  = 3'b011;
  localparam logic [2:0] ERR_LD_MISALIGN = 3'b110;
  localparam logic [2:0] ERR_ST_MISALIGN = 3'b111;
  localparam logic [7:0] CAUSE_PC_MISALIGN = 8'd0;
  localparam logic [7:0] CAUSE_IMEM_FAULT  = 8'd1;
  localparam logic [7:0] CAUSE_ILLEGAL     = 8'd2;
  localparam logic [7:0] CAUSE_M_SW        = 8'd3;
  localparam logic [7:0] CAUSE_LD_MISALIGN = 8'd4;
  localparam logic [7:0] CAUSE_LD_FAULT    = 8'd5;
  localparam logic [7:0] CAUSE_ST_MISALIGN = 8'd6;
  localparam logic [7:0] CAUSE_ST_FAULT    = 8'd7;
  localparam logic [7:0] CAUSE_M_TMR       = 8'd7;
  localparam logic [7:0] CAUSE_ECALL       = 8'd11;
  localparam logic [7:0] CAUSE_M_EXT       = 8'd11;
  localparam int LCL_ITR_CAUSE_BASE = 16;
  localparam logic LSU_ERR_LOAD  = 1'b0;
  localparam logic LSU_ERR_STORE = 1'b1;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} cmt_state_e;
  function automatic logic [7:0] expt_cause(input logic [2:0] err);
    return err == ERR_ILLEGAL ? CAUSE_ILLEGAL :
           err == ERR_PC_MISALIGN ? CAUSE_PC_MISALIGN :
           err == ERR_IMEM_FAULT ? CAUSE_IMEM_FAULT :
           err == ERR_LD_MISALIGN ? CAUSE_LD_MISALIGN :
           err == ERR_ST_MISALIGN ? CAUSE_ST_MISALIGN : CAUSE_PC_MISALIGN;
  endfunction
  // Index 0..2 are ext/sw/tmr; local line i sits at index 3+i.
  function automatic logic [7:0] itr_cause(input int idx);
    return idx == 0 ? CAUSE_M_EXT : idx == 1 ? CAUSE_M_SW : idx == 2 ? CAUSE_M_TMR :
           8'(LCL_ITR_CAUSE_BASE + idx - 3);
  endfunction
endpackage

// File: rtl/panda_risc_v_itr_arbiter.sv
// panda_risc_v_itr_arbiter: fixed-priority interrupt picker, index 0 wins
module panda_risc_v_itr_arbiter import panda_risc_v_pkg::*; #(
  parameter int N = 7
) (
  input  logic [N-1:0] req,
  output logic         any_vld,
  output logic [7:0]   cause
);
  assign any_vld = |req;
  always_comb begin
    cause = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) cause = itr_cause(i);
  end
endmodule

// File: rtl/panda_risc_v_commit_pro.sv
// panda_risc_v_commit_pro: branch confirm, commit/cancel, trap arbitration and flush sequencing
module panda_risc_v_commit_pro import panda_risc_v_pkg::*; #(
  parameter int simulation_delay = 1,
  parameter int LOCAL_ITR_N = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mstatus_mie_v,
  input  logic                   mie_msie_v,
  input  logic                   mie_mtie_v,
  input  logic                   mie_meie_v,
  input  logic [LOCAL_ITR_N-1:0] mie_lcl_v,
  input  logic                   sw_itr_req,
  input  logic                   tmr_itr_req,
  input  logic                   ext_itr_req,
  input  logic [LOCAL_ITR_N-1:0] lcl_itr_req,
  input  logic [31:0]            s_pst_inst,
  input  logic [31:0]            s_pst_pc_of_inst,
  input  logic [31:0]            s_pst_brc_pc_upd,
  input  logic [2:0]             s_pst_err_code,
  input  logic                   s_pst_is_b_inst,
  input  logic                   s_pst_is_ecall_inst,
  input  logic                   s_pst_is_mret_inst,
  input  logic                   s_pst_prdt_jump,
  input  logic                   s_pst_rd_vld,
  input  logic                   s_pst_is_long_inst,
  input  logic                   s_pst_valid,
  output logic                   s_pst_ready,
  input  logic [31:0]            s_lsu_expt_ls_addr,
  input  logic                   s_lsu_expt_err,
  input  logic                   s_lsu_expt_valid,
  output logic                   s_lsu_expt_ready,
  input  logic [31:0]            ls_addr,
  input  logic                   cfr_jump,
  output logic                   m_pst_inst_cmt,
  output logic                   m_pst_wb_imdt,
  output logic                   m_pst_valid,
  input  logic                   m_pst_ready,
  output logic                   itr_expt_enter,
  output logic                   itr_expt_is_intr,
  output logic                   itr_expt_ret,
  output logic [7:0]             itr_expt_cause,
  output logic [31:0]            itr_expt_ret_addr,
  output logic [31:0]            itr_expt_val,
  input  logic [31:0]            itr_expt_vec_baseaddr,
  input  logic [31:0]            mepc_ret_addr,
  output logic                   flush_req,
  output logic [31:0]            flush_addr,
  input  logic                   flush_ack,
  output logic                   dbl_fault
);
  localparam int N = LOCAL_ITR_N + 3;
  cmt_state_e state_q, state_d;
  logic trap_proc_q, trap_proc_d, lsu_pend_q, lsu_pend_d, lsu_err_q, lsu_err_d, dbl_fault_q, dbl_fault_d;
  logic [31:0] lsu_addr_q, lsu_addr_d, flush_addr_q, flush_addr_d;
  logic run, commit, clean, ctrl, mispred, sync_expt, ecall, mret, halt, itr_take, lsu_take, flush_go;
  logic [N-1:0] itr_req;
  logic itr_vld;
  logic [7:0] itr_cause_w;
  assign itr_req = {lcl_itr_req & mie_lcl_v, tmr_itr_req & mie_mtie_v, sw_itr_req & mie_msie_v,
                    ext_itr_req & mie_meie_v} & {N{mstatus_mie_v}};
  panda_risc_v_itr_arbiter #(.N(N)) u_arb (.req(itr_req), .any_vld(itr_vld), .cause(itr_cause_w));
  assign run = state_q == ST_RUN;
  assign s_pst_ready = run & m_pst_ready;
  assign m_pst_valid = run & s_pst_valid;
  assign commit = s_pst_valid & s_pst_ready;
  assign clean = s_pst_err_code[1:0] == 2'b00;
  assign ctrl = s_pst_is_b_inst | s_pst_is_ecall_inst | s_pst_is_mret_inst | (s_pst_err_code != ERR_NONE);
  assign mispred = clean & s_pst_is_b_inst & (s_pst_prdt_jump ^ cfr_jump);
  assign sync_expt = ~clean;
  assign ecall = clean & s_pst_is_ecall_inst & ~mispred;
  assign mret = clean & s_pst_is_mret_inst & ~mispred & ~s_pst_is_ecall_inst;
  // A faulting instruction inside a handler halts instead of trapping again.
  assign halt = commit & sync_expt & trap_proc_q;
  assign itr_take = ~ctrl & itr_vld;
  assign lsu_take = ~ctrl & ~itr_vld & lsu_pend_q & ~trap_proc_q;
  assign itr_expt_enter = commit & ~halt & (sync_expt | ecall | itr_take | lsu_take);
  assign itr_expt_is_intr = commit & itr_take;
  assign itr_expt_ret = commit & mret;
  assign flush_go = commit & ~halt & (mispred | itr_expt_enter | mret);
  assign m_pst_inst_cmt = m_pst_valid & clean;
  assign m_pst_wb_imdt = m_pst_valid & s_pst_rd_vld & ~s_pst_is_long_inst;
  assign s_lsu_expt_ready = ~lsu_pend_q;
  assign flush_req = state_q == ST_FLUSH;
  assign flush_addr = flush_addr_q;
  assign dbl_fault = dbl_fault_q;
  always_comb begin
    itr_expt_cause = ~itr_expt_enter ? 8'd0 : sync_expt ? expt_cause(s_pst_err_code) :
                     ecall ? CAUSE_ECALL : itr_take ? itr_cause_w :
                     lsu_err_q == LSU_ERR_STORE ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    itr_expt_ret_addr = ~itr_expt_enter ? 32'd0 : (sync_expt | ecall) ? s_pst_pc_of_inst :
                        s_pst_pc_of_inst + 32'd4;
    itr_expt_val = ~itr_expt_enter ? 32'd0 : lsu_take ? lsu_addr_q : ~sync_expt ? 32'd0 :
                   s_pst_err_code[2] ? ls_addr : s_pst_err_code == ERR_ILLEGAL ? s_pst_inst :
                   s_pst_pc_of_inst;
  end
  always_comb begin
    state_d = state_q;
    state_d = halt ? ST_HALT : flush_go ? ST_FLUSH :
              (state_q == ST_FLUSH && flush_ack) ? ST_RUN : state_q;
    flush_addr_d = ~flush_go ? flush_addr_q : mispred ? s_pst_brc_pc_upd :
                   mret ? mepc_ret_addr : itr_expt_vec_baseaddr;
    trap_proc_d = itr_expt_ret ? 1'b0 : itr_expt_enter ? 1'b1 : trap_proc_q;
    lsu_pend_d = (s_lsu_expt_valid & ~lsu_pend_q) | (lsu_pend_q & ~(commit & lsu_take));
    lsu_addr_d = (s_lsu_expt_valid & ~lsu_pend_q) ? s_lsu_expt_ls_addr : lsu_addr_q;
    lsu_err_d = (s_lsu_expt_valid & ~lsu_pend_q) ? s_lsu_expt_err : lsu_err_q;
    dbl_fault_d = dbl_fault_q | halt;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      flush_addr_q <= '0;
      trap_proc_q <= 1'b0;
      lsu_pend_q <= 1'b0;
      lsu_addr_q <= '0;
      lsu_err_q <= 1'b0;
      dbl_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_addr_q <= flush_addr_d;
      trap_proc_q <= trap_proc_d;
      lsu_pend_q <= lsu_pend_d;
      lsu_addr_q <= lsu_addr_d;
      lsu_err_q <= lsu_err_d;
      dbl_fault_q <= dbl_fault_d;
    end
  end
endmodule
